// File: rtl/fpadd_pkg.sv
// Shared types and constants for the float-adder arbiter and its bench.
package fpadd_pkg;

    localparam int FP_W = 32;

    // Which requester an in-flight adder operation belongs to
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // One stage of the owner-tracking pipeline
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    function automatic tag_t mk_tag(input logic vld, input owner_e own);
        tag_t t;
        t.valid = vld;
        t.owner = own;
        return t;
    endfunction

endpackage

// File: rtl/fpadd_res_fifo.sv
// Per-requester result FIFO: push from adder writeback, pop on consumer ack.
// A pop while empty is ignored; data pushed into an empty FIFO shows up on
// o_head the following cycle. Callers guarantee no push while full.
module fpadd_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

    // Storage array; data only, no reset needed
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Two-requester front end for a shared, non-stalling, pipelined FP adder.
// Round-robin arbitration with per-requester credit checks, an owner tag
// pipeline matching the adder latency, and one result FIFO per requester.
// Build option: define FPADD_ARB_FIXED_PRIO_EN to make A win every contention
// (no round-robin pointer is built in that case).
module fpadd_arbiter
    import fpadd_pkg::*;
#(
    parameter int LATENCY   = 3,
    parameter int RES_DEPTH = 4,
    parameter int CIN_VAL   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [FP_W-1:0] a_x,
    input  logic [FP_W-1:0] a_y,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [FP_W-1:0] b_x,
    input  logic [FP_W-1:0] b_y,
    output logic            b_ready,
    output logic            a_res_valid,
    output logic [FP_W-1:0] a_res,
    input  logic            a_res_ack,
    output logic            b_res_valid,
    output logic [FP_W-1:0] b_res,
    input  logic            b_res_ack,
    output logic [FP_W-1:0] fa_x,
    output logic [FP_W-1:0] fa_y,
    output logic            fa_cin,
    input  logic [FP_W-1:0] fa_s,
    output logic            busy
);

    localparam int          CW  = $clog2(RES_DEPTH) + 1;
    localparam logic [CW:0] CAP = RES_DEPTH[CW:0];

    logic [1:0]           w_valid;
    logic [1:0]           w_ack;
    logic [1:0]           w_elig;
    logic [1:0]           w_gnt;
    logic [1:0]           w_wb;
    logic [1:0][FP_W-1:0] w_head;
    logic [1:0][CW-1:0]   w_cnt;
    tag_t [LATENCY-1:0]   r_tag;
    tag_t                 w_tag_fin;
    logic                 w_pick_b;
    logic                 w_any_tag;
    logic [FP_W-1:0]      r_fa_x;
    logic [FP_W-1:0]      r_fa_y;

    assign w_valid   = {b_valid, a_valid};
    assign w_ack     = {b_res_ack, a_res_ack};
    assign w_tag_fin = r_tag[LATENCY-1];

    // Per-requester credit tracking and result storage
    generate
        for (genvar g = 0; g < 2; g++) begin : g_lane
            localparam owner_e LANE = (g == 0) ? OWN_A : OWN_B;

            logic [CW-1:0] r_out;

            // Credits cover both in-flight ops and buffered results, so a
            // writeback always finds room even though the adder never stalls.
            assign w_elig[g] = w_valid[g] &&
                               (({1'b0, r_out} + {1'b0, w_cnt[g]}) < CAP);
            assign w_wb[g]   = w_tag_fin.valid && (w_tag_fin.owner == LANE);

            // Outstanding count: +1 on grant, -1 on writeback, both cancel
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out <= '0;
                end else begin
                    case ({w_gnt[g], w_wb[g]})
                        2'b10:   r_out <= r_out + 1'b1;
                        2'b01:   r_out <= r_out - 1'b1;
                        default: r_out <= r_out;
                    endcase
                end
            end

            fpadd_res_fifo #(
                .DEPTH (RES_DEPTH),
                .WIDTH (FP_W)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_wb[g]),
                .i_data  (fa_s),
                .i_pop   (w_ack[g]),
                .o_head  (w_head[g]),
                .o_count (w_cnt[g])
            );

            // Writeback into a full FIFO would silently drop a result
            a_no_overflow: assert property (@(posedge clk) disable iff (rst)
                !(w_wb[g] && (w_cnt[g] == CAP[CW-1:0])));
        end
    endgenerate

`ifdef FPADD_ARB_FIXED_PRIO_EN
    assign w_pick_b = 1'b0;
`else
    logic r_rr;

    // Round-robin pointer: 0 favours A, flips only when both were eligible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (&w_elig) begin
            r_rr <= ~r_rr;
        end
    end

    assign w_pick_b = r_rr;
`endif

    // Grant selection; ready is held low while reset is asserted
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            if (&w_elig) begin
                w_gnt = w_pick_b ? 2'b10 : 2'b01;
            end else begin
                w_gnt = w_elig;
            end
        end
    end

    assign a_ready = w_gnt[0];
    assign b_ready = w_gnt[1];

    // Issue register and owner tag pipeline; operands hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fa_x <= '0;
            r_fa_y <= '0;
            r_tag  <= '0;
        end else begin
            r_tag[0] <= mk_tag(|w_gnt, w_gnt[1] ? OWN_B : OWN_A);
            for (int i = 1; i < LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (|w_gnt) begin
                r_fa_x <= w_gnt[1] ? b_x : a_x;
                r_fa_y <= w_gnt[1] ? b_y : a_y;
            end
        end
    end

    // Any tag stage still carrying an operation
    always_comb begin
        w_any_tag = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            w_any_tag = w_any_tag | r_tag[i].valid;
        end
    end

    assign fa_x        = r_fa_x;
    assign fa_y        = r_fa_y;
    assign fa_cin      = (CIN_VAL != 0);
    assign a_res_valid = (w_cnt[0] != '0);
    assign b_res_valid = (w_cnt[1] != '0);
    assign a_res       = w_head[0];
    assign b_res       = w_head[1];
    assign busy        = w_any_tag | (|w_cnt[0]) | (|w_cnt[1]);

    a_one_grant: assert property (@(posedge clk) disable iff (rst) !(&w_gnt));

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Self-checking bench for fpadd_arbiter with a behavioural pipelined adder.
module tb_fpadd_arbiter;
    import fpadd_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [31:0] a_x, a_y, b_x, b_y;
    logic        a_res_valid, b_res_valid, a_res_ack, b_res_ack;
    logic [31:0] a_res, b_res;
    logic [31:0] fa_x, fa_y, fa_s;
    logic        fa_cin, busy;

    fpadd_arbiter #(.LATENCY(LAT), .RES_DEPTH(DEPTH), .CIN_VAL(1)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_x(a_x), .a_y(a_y), .a_ready(a_ready),
        .b_valid(b_valid), .b_x(b_x), .b_y(b_y), .b_ready(b_ready),
        .a_res_valid(a_res_valid), .a_res(a_res), .a_res_ack(a_res_ack),
        .b_res_valid(b_res_valid), .b_res(b_res), .b_res_ack(b_res_ack),
        .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin), .fa_s(fa_s), .busy(busy)
    );

    always #5 clk = ~clk;

    // Positive normal operands only, exact cases; enough for the vectors used
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        logic [7:0]  ex, d;
        logic [24:0] mx, my, s;
        if (x[30:23] < y[30:23]) begin t = x; x = y; y = t; end
        ex = x[30:23];
        d  = x[30:23] - y[30:23];
        mx = {2'b01, x[22:0]};
        my = {2'b01, y[22:0]};
        my = (d > 8'd24) ? 25'd0 : (my >> d);
        s  = mx + my;
        if (s[24]) begin s = s >> 1; ex = ex + 8'd1; end
        return {1'b0, ex, s[22:0]};
    endfunction

    // Adder model: operand register lives in the DUT, LAT-1 more stages here
    logic [31:0] add_c;
    logic [31:0] add_q [LAT-1];
    always_comb add_c = fadd(fa_x, fa_y);
    always_ff @(posedge clk) begin
        add_q[0] <= add_c;
        for (int i = 1; i < LAT - 1; i++) add_q[i] <= add_q[i-1];
    end
    assign fa_s = add_q[LAT-2];

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
    } vec_t;
    vec_t vt [6];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] a_cur_exp, b_cur_exp;
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    bit          glog [$];
    bit          a_ack_en, b_ack_en;
    int          a_ack_req = 0, a_ack_done = 0, b_ack_req = 0, b_ack_done = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on handshake, pop and compare on consumer ack
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_a.delete();
                exp_b.delete();
            end else begin
                if (a_ready && b_ready) begin
                    checks++; errors++;
                    $display("FAIL double_grant: got both ready expected one");
                end
                if (a_valid && a_ready) begin exp_a.push_back(a_cur_exp); glog.push_back(1'b0); end
                if (b_valid && b_ready) begin exp_b.push_back(b_cur_exp); glog.push_back(1'b1); end
                if (a_res_valid && a_res_ack) begin
                    if (exp_a.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL a_res_extra: got %h expected nothing", a_res);
                    end else check32("a_res", a_res, exp_a.pop_front());
                end
                if (b_res_valid && b_res_ack) begin
                    if (exp_b.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_res_extra: got %h expected nothing", b_res);
                    end else check32("b_res", b_res, exp_b.pop_front());
                end
            end
        end
    endtask

    // Consumer: ack continuously when enabled, or single requested pulses
    task automatic acker();
        forever begin
            @(posedge clk);
            #1;
            a_res_ack = a_res_valid && (a_ack_en || a_ack_req != a_ack_done);
            if (a_res_ack && !a_ack_en) a_ack_done++;
            b_res_ack = b_res_valid && (b_ack_en || b_ack_req != b_ack_done);
            if (b_res_ack && !b_ack_en) b_ack_done++;
        end
    endtask

    task automatic send_one(input bit side, input vec_t v);
        int n;
        if (!side) begin a_valid = 1; a_x = v.x; a_y = v.y; a_cur_exp = v.e; end
        else begin b_valid = 1; b_x = v.x; b_y = v.y; b_cur_exp = v.e; end
        @(negedge clk);
        check1(side ? "b_ready" : "a_ready", side ? b_ready : a_ready, 1'b1);
        tick();
        a_valid = 0; b_valid = 0;
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (side ? b_res_valid : a_res_valid) break;
            @(posedge clk);
            n++;
        end
        check_int("latency", n, LAT + 1);
        repeat (3) tick();
    endtask

    initial begin
        int base, g, ga, gb, ka, kb, cnt;
        bit exp6 [4];

        vt[0] = '{32'h3FC0_0000, 32'h41B8_0000, 32'h41C4_0000};
        vt[1] = '{FP_ONE,        FP_ONE,        32'h4000_0000};
        vt[2] = '{32'h4000_0000, 32'h4000_0000, 32'h4080_0000};
        vt[3] = '{FP_ONE,        32'h4000_0000, 32'h4040_0000};
        vt[4] = '{32'h4040_0000, 32'h40A0_0000, 32'h4100_0000};
        vt[5] = '{32'h3F00_0000, 32'h3F00_0000, FP_ONE};

        rst = 1; a_valid = 0; b_valid = 0; a_x = 0; a_y = 0; b_x = 0; b_y = 0;
        a_res_ack = 0; b_res_ack = 0; a_ack_en = 1; b_ack_en = 1;
        a_cur_exp = 0; b_cur_exp = 0;

        fork
            monitor();
            acker();
            begin
                #500000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "bench timeout");
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_a_ready", a_ready, 1'b0);
        check1("rst_b_ready", b_ready, 1'b0);
        check1("rst_a_res_valid", a_res_valid, 1'b0);
        check1("rst_b_res_valid", b_res_valid, 1'b0);
        check32("rst_fa_x", fa_x, 32'h0);
        check32("rst_fa_y", fa_y, 32'h0);
        check1("rst_busy", busy, 1'b0);
        check1("fa_cin", fa_cin, 1'b1);
        tick();
        rst = 0;
        repeat (2) tick();

        // Single requests, alternating sides; first one is 1.5 + 23.0
        for (int i = 0; i < 6; i++) send_one(i[0], vt[i]);

        // Contention: grants alternate starting at A
        base = glog.size();
        a_valid = 1; a_x = FP_ONE; a_y = FP_ONE; a_cur_exp = 32'h4000_0000;
        b_valid = 1; b_x = 32'h4000_0000; b_y = 32'h4000_0000; b_cur_exp = 32'h4080_0000;
        repeat (8) tick();
        a_valid = 0; b_valid = 0;
`ifndef FPADD_ARB_FIXED_PRIO_EN
        check_int("t2_grants", glog.size() - base, 8);
        for (int i = 0; i < 8; i++)
            if (base + i < glog.size()) check1("t2_order", glog[base+i], (i % 2) == 1);
`endif
        repeat (12) tick();
        check_int("t2_drain_a", exp_a.size(), 0);
        check_int("t2_drain_b", exp_b.size(), 0);

        // Backpressure on B: exactly DEPTH grants, then one per ack
        b_ack_en = 0; g = 0; kb = 0;
        repeat (12) begin
            b_valid = 1; b_x = vt[kb%6].x; b_y = vt[kb%6].y; b_cur_exp = vt[kb%6].e;
            @(negedge clk);
            if (b_ready) begin g++; kb++; end
            tick();
        end
        check_int("t3_grants", g, DEPTH);
        @(negedge clk);
        check1("t3_ready_low", b_ready, 1'b0);
        check1("t3_res_valid", b_res_valid, 1'b1);
        tick();
        b_ack_req++;
        g = 0;
        repeat (10) begin
            b_valid = 1; b_x = vt[kb%6].x; b_y = vt[kb%6].y; b_cur_exp = vt[kb%6].e;
            @(negedge clk);
            if (b_ready) begin g++; kb++; end
            tick();
        end
        check_int("t3_one_more", g, 1);
        b_valid = 0; b_ack_en = 1;
        repeat (12) tick();
        check_int("t3_drain_b", exp_b.size(), 0);

        // Mixed: A stalls on a full FIFO, B takes every issued slot
        a_ack_en = 0; ka = 0; kb = 0; ga = 0; gb = 0;
        for (int c = 0; c < 24; c++) begin
            a_valid = 1; a_x = vt[ka%6].x; a_y = vt[ka%6].y; a_cur_exp = vt[ka%6].e;
            b_valid = 1; b_x = vt[kb%6].x; b_y = vt[kb%6].y; b_cur_exp = vt[kb%6].e;
            @(negedge clk);
            if (a_ready) begin ka++; if (c >= 14) ga++; end
            if (b_ready) begin kb++; if (c >= 14) gb++; end
            tick();
        end
        check_int("t4_a_total", ka, DEPTH);
        check_int("t4_a_late", ga, 0);
        check_int("t4_b_late", gb, 8);
        a_valid = 0; b_valid = 0; a_ack_en = 1;
        repeat (14) tick();
        check_int("t4_drain_a", exp_a.size(), 0);
        check_int("t4_drain_b", exp_b.size(), 0);

        // Reset with two operations in flight
        a_valid = 1; a_x = vt[0].x; a_y = vt[0].y; a_cur_exp = vt[0].e;
        tick();
        a_valid = 0;
        b_valid = 1; b_x = vt[1].x; b_y = vt[1].y; b_cur_exp = vt[1].e;
        tick();
        b_valid = 0;
        check1("t5_busy_before", busy, 1'b1);
        #2;
        rst = 1; a_valid = 1; b_valid = 1;
        #1;
        check1("t5_busy", busy, 1'b0);
        check1("t5_a_ready", a_ready, 1'b0);
        check1("t5_b_ready", b_ready, 1'b0);
        check1("t5_a_res_valid", a_res_valid, 1'b0);
        check1("t5_b_res_valid", b_res_valid, 1'b0);
        check32("t5_fa_x", fa_x, 32'h0);
        check32("t5_fa_y", fa_y, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        a_valid = 0; b_valid = 0; rst = 0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (a_res_valid || b_res_valid) cnt++;
            tick();
        end
        check_int("t5_no_results", cnt, 0);
        check1("t5_busy_after", busy, 1'b0);

        // Both valid from a fresh reset, then A drops
`ifdef FPADD_ARB_FIXED_PRIO_EN
        exp6 = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp6 = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        base = glog.size();
        a_valid = 1; a_x = vt[2].x; a_y = vt[2].y; a_cur_exp = vt[2].e;
        b_valid = 1; b_x = vt[3].x; b_y = vt[3].y; b_cur_exp = vt[3].e;
        repeat (3) tick();
        a_valid = 0;
        tick();
        b_valid = 0;
        check_int("t6_grants", glog.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (base + i < glog.size()) check1("t6_order", glog[base+i], exp6[i]);
        repeat (12) tick();
        check_int("t6_drain_a", exp_a.size(), 0);
        check_int("t6_drain_b", exp_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
